// File: rtl/vx_mask_encoder.sv
// -----------------------------------------------------------------------------
// vx_mask_encoder
//
// Streaming bitmask-to-index encoder. Each accepted D-bit mask (with a
// sideband tag) is serialized into one output beat per set bit, carrying the
// bit's binary index. Beats are emitted lowest index first by default. An
// all-zero mask produces a single terminator beat flagged with empty_out.
// Every mask ends with exactly one beat that has last_out set.
//
// Optional build macro:
//   VX_MASK_ENCODER_MSB_FIRST_EN - when defined, set bits are emitted highest
//                                  index first. The zero-mask terminator beat
//                                  is unchanged. Ports and latency are the
//                                  same in both builds.
//
// Parameters:
//   N          index width in bits (mask width D = 1 << N, N >= 1)
//   TAG_WIDTH  width of the sideband tag (>= 1)
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   valid_in   input mask valid
//   mask_in    D-bit mask to encode
//   tag_in     sideband tag travelling with the mask
//   ready_in   block can accept a mask this cycle
//   valid_out  output beat valid
//   index_out  index of the current set bit
//   tag_out    tag of the mask being encoded
//   last_out   final beat for this mask
//   empty_out  mask was all-zero (single terminator beat)
//   ready_out  downstream accepts the beat
// -----------------------------------------------------------------------------
module vx_mask_encoder #(
  parameter int  N         = 3,
  parameter int  TAG_WIDTH = 1,
  localparam int D         = 1 << N
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 valid_in,
  input  logic [D-1:0]         mask_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 ready_in,
  output logic                 valid_out,
  output logic [N-1:0]         index_out,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 last_out,
  output logic                 empty_out,
  input  logic                 ready_out
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [N-1:0]         index_q, index_d;
  logic [TAG_WIDTH-1:0] tag_q, tag_d;
  logic                 last_q, last_d;
  logic                 empty_q, empty_d;
  logic [D-1:0]         remaining_q, remaining_d;

  logic                 accept;
  logic                 beat;
  logic [D-1:0]         pick_src;
  logic [N-1:0]         pick;
  logic [D-1:0]         cleared;

  localparam logic [D-1:0] ONE = D'(1);

  // Selects the next set bit to emit from a mask. The loop direction makes
  // the last matching assignment win, which gives a simple priority encoder.
  // For an all-zero mask the result is 0; callers handle that case.
  function automatic logic [N-1:0] pick_index(input logic [D-1:0] m);
    logic [N-1:0] idx;
    idx = '0;
`ifdef VX_MASK_ENCODER_MSB_FIRST_EN
    for (int i = 0; i < D; i++) begin
      if (m[i]) idx = N'(i);
    end
`else
    for (int i = D - 1; i >= 0; i--) begin
      if (m[i]) idx = N'(i);
    end
`endif
    return idx;
  endfunction

  assign accept = valid_in && ready_in;
  assign beat   = valid_out && ready_out;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      index_q     <= '0;
      tag_q       <= '0;
      last_q      <= 1'b0;
      empty_q     <= 1'b0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      tag_q       <= tag_d;
      last_q      <= last_d;
      empty_q     <= empty_d;
      remaining_q <= remaining_d;
    end
  end

  // Next-state logic. A new mask can only be accepted while idle or on the
  // last beat of the current mask, so a single shared priority encoder serves
  // both the fresh mask and the remaining bits of the current one.
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    tag_d       = tag_q;
    last_d      = last_q;
    empty_d     = empty_q;
    remaining_d = remaining_q;

    pick_src = accept ? mask_in : remaining_q;
    pick     = pick_index(pick_src);
    cleared  = pick_src & ~(ONE << pick);

    if (accept) begin
      state_d = SCAN;
      tag_d   = tag_in;
      if (mask_in == '0) begin
        index_d     = '0;
        last_d      = 1'b1;
        empty_d     = 1'b1;
        remaining_d = '0;
      end else begin
        index_d     = pick;
        remaining_d = cleared;
        last_d      = (cleared == '0);
        empty_d     = 1'b0;
      end
    end else if (beat) begin
      if (last_q) begin
        // Beat fields are left as-is; they are meaningless once valid drops.
        state_d = IDLE;
      end else begin
        index_d     = pick;
        remaining_d = cleared;
        last_d      = (cleared == '0);
      end
    end
  end

  // Output logic. ready_in is deliberately independent of valid_in so that
  // upstream can use it without a combinational loop.
  always_comb begin
    valid_out = (state_q == SCAN);
    ready_in  = (state_q == IDLE) || (valid_out && ready_out && last_q);
    index_out = index_q;
    tag_out   = tag_q;
    last_out  = last_q;
    empty_out = empty_q;
  end

endmodule
